// File: rtl/vdp_palette_rgb.sv
// VDP RGB palette RAM: CPU two-byte palette write port with auto-incrementing
// pointer, registered video read port, and a post-reset default palette loader.
module vdp_palette_rgb #(
    parameter int ADDR_BITS = 8,
    parameter int CH_BITS   = 3
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 PAL_ADR_WE,
    input  logic [ADDR_BITS-1:0] PAL_ADR_DATA,
    input  logic                 PAL_WR,
    input  logic [7:0]           PAL_DATA,
    output logic [ADDR_BITS-1:0] PAL_PTR,
    output logic                 PAL_BUSY,
    input  logic [ADDR_BITS-1:0] VID_ADR,
    output logic [CH_BITS-1:0]   VID_R,
    output logic [CH_BITS-1:0]   VID_G,
    output logic [CH_BITS-1:0]   VID_B
);

    localparam int ENTRIES = 1 << ADDR_BITS;
    localparam int W       = 3 * CH_BITS;

    typedef enum logic [1:0] {ST_INIT, ST_FIRST, ST_SECOND} state_t;

    state_t               state_reg, state_next;
    logic [ADDR_BITS-1:0] init_cnt_reg, init_cnt_next;
    logic [ADDR_BITS-1:0] ptr_reg, ptr_next;
    logic [CH_BITS-1:0]   r_reg, r_next;
    logic [CH_BITS-1:0]   b_reg, b_next;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [W-1:0]         wr_data;
    logic [W-1:0]         vid_rgb_reg;
    logic [W-1:0]         mem [ENTRIES];
    logic                 unused_data_bits;

    assign unused_data_bits = &{1'b0, PAL_DATA};

    // MSX default palette as octal {R,G,B}; widened channels get a zero LSB.
    function automatic logic [W-1:0] default_rgb(input logic [ADDR_BITS-1:0] idx);
        logic [8:0]         rgb9;
        logic [CH_BITS-1:0] r, g, b;
        rgb9 = '0;
        if (32'(idx) < 32'd16) begin
            case (4'(idx))
                4'd2:    rgb9 = 9'o161;
                4'd3:    rgb9 = 9'o373;
                4'd4:    rgb9 = 9'o117;
                4'd5:    rgb9 = 9'o237;
                4'd6:    rgb9 = 9'o511;
                4'd7:    rgb9 = 9'o267;
                4'd8:    rgb9 = 9'o711;
                4'd9:    rgb9 = 9'o733;
                4'd10:   rgb9 = 9'o661;
                4'd11:   rgb9 = 9'o664;
                4'd12:   rgb9 = 9'o141;
                4'd13:   rgb9 = 9'o625;
                4'd14:   rgb9 = 9'o555;
                4'd15:   rgb9 = 9'o777;
                default: rgb9 = 9'o000;
            endcase
        end
        r = CH_BITS'(rgb9[8:6]) << (CH_BITS - 3);
        g = CH_BITS'(rgb9[5:3]) << (CH_BITS - 3);
        b = CH_BITS'(rgb9[2:0]) << (CH_BITS - 3);
        return {r, g, b};
    endfunction

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
            ptr_reg      <= '0;
            r_reg        <= '0;
            b_reg        <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            ptr_reg      <= ptr_next;
            r_reg        <= r_next;
            b_reg        <= b_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        ptr_next      = ptr_reg;
        r_next        = r_reg;
        b_next        = b_reg;
        wr_en         = 1'b0;
        wr_addr       = ptr_reg;
        wr_data       = {r_reg, PAL_DATA[CH_BITS-1:0], b_reg};
        case (state_reg)
            ST_INIT: begin
                wr_en         = 1'b1;
                wr_addr       = init_cnt_reg;
                wr_data       = default_rgb(init_cnt_reg);
                init_cnt_next = init_cnt_reg + ADDR_BITS'(1);
                if (init_cnt_reg == ADDR_BITS'(ENTRIES - 1))
                    state_next = ST_FIRST;
            end
            ST_FIRST, ST_SECOND: begin
                // A pointer load takes priority and abandons any half-written pair.
                if (PAL_ADR_WE) begin
                    ptr_next   = PAL_ADR_DATA;
                    r_next     = '0;
                    b_next     = '0;
                    state_next = ST_FIRST;
                end else if (PAL_WR) begin
                    if (state_reg == ST_FIRST) begin
                        r_next     = PAL_DATA[4+CH_BITS-1:4];
                        b_next     = PAL_DATA[CH_BITS-1:0];
                        state_next = ST_SECOND;
                    end else begin
                        wr_en      = 1'b1;
                        ptr_next   = ptr_reg + ADDR_BITS'(1);
                        state_next = ST_FIRST;
                    end
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read-before-write: a same-index collision returns the previous contents.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            vid_rgb_reg <= '0;
        else
            vid_rgb_reg <= mem[VID_ADR];
    end

    assign VID_R    = vid_rgb_reg[W-1:2*CH_BITS];
    assign VID_G    = vid_rgb_reg[2*CH_BITS-1:CH_BITS];
    assign VID_B    = vid_rgb_reg[CH_BITS-1:0];
    assign PAL_PTR  = ptr_reg;
    assign PAL_BUSY = (state_reg == ST_INIT);

endmodule

// File: tb/tb_vdp_palette_rgb.sv
// Self-checking bench for vdp_palette_rgb (ADDR_BITS=8, CH_BITS=3) against a
// behavioural palette model built from arrays and the two-byte write rule.
module tb_vdp_palette_rgb;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       PAL_ADR_WE = 1'b0;
    logic [7:0] PAL_ADR_DATA = '0;
    logic       PAL_WR = 1'b0;
    logic [7:0] PAL_DATA = '0;
    logic [7:0] PAL_PTR;
    logic       PAL_BUSY;
    logic [7:0] VID_ADR = '0;
    logic [2:0] VID_R, VID_G, VID_B;

    int errors = 0;
    int checks = 0;

    int def_r [16] = '{0,0,1,3,1,2,5,2,7,7,6,6,1,6,5,7};
    int def_g [16] = '{0,0,6,7,1,3,1,6,1,3,6,6,4,2,5,7};
    int def_b [16] = '{0,0,1,3,7,7,1,7,1,3,1,4,1,5,5,7};

    int mr [256];
    int mg [256];
    int mb [256];
    int m_ptr, m_phase, m_r, m_b;

    vdp_palette_rgb #(.ADDR_BITS(8), .CH_BITS(3)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .PAL_ADR_WE(PAL_ADR_WE), .PAL_ADR_DATA(PAL_ADR_DATA),
        .PAL_WR(PAL_WR), .PAL_DATA(PAL_DATA),
        .PAL_PTR(PAL_PTR), .PAL_BUSY(PAL_BUSY),
        .VID_ADR(VID_ADR), .VID_R(VID_R), .VID_G(VID_G), .VID_B(VID_B)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            mr[i] = (i < 16) ? def_r[i] : 0;
            mg[i] = (i < 16) ? def_g[i] : 0;
            mb[i] = (i < 16) ? def_b[i] : 0;
        end
        m_ptr = 0; m_phase = 0; m_r = 0; m_b = 0;
    endtask

    task automatic model_wr(input int d);
        if (m_phase == 0) begin
            m_r = (d / 16) % 8;
            m_b = d % 8;
            m_phase = 1;
        end else begin
            mr[m_ptr] = m_r;
            mg[m_ptr] = d % 8;
            mb[m_ptr] = m_b;
            m_ptr = (m_ptr + 1) % 256;
            m_phase = 0;
        end
    endtask

    task automatic pulse_wr(input logic [7:0] d);
        PAL_WR = 1'b1; PAL_DATA = d;
        step();
        PAL_WR = 1'b0;
        model_wr(int'(d));
        $display("wr   data=0x%02h ptr=%0d", d, PAL_PTR);
    endtask

    task automatic set_ptr(input logic [7:0] a);
        PAL_ADR_WE = 1'b1; PAL_ADR_DATA = a;
        step();
        PAL_ADR_WE = 1'b0;
        m_ptr = int'(a); m_phase = 0;
        $display("adr  ptr<=%0d", a);
    endtask

    task automatic read_rgb(input string tag, input int idx, input int er, input int eg, input int eb);
        VID_ADR = 8'(idx);
        step();
        $display("rd   %s idx=%0d rgb=(%0d,%0d,%0d)", tag, idx, VID_R, VID_G, VID_B);
        chk({tag, ".r"}, 32'(VID_R), 32'(er));
        chk({tag, ".g"}, 32'(VID_G), 32'(eg));
        chk({tag, ".b"}, 32'(VID_B), 32'(eb));
    endtask

    task automatic read_model(input string tag, input int idx);
        read_rgb(tag, idx, mr[idx], mg[idx], mb[idx]);
    endtask

    // Releases reset and counts busy cycles while throwing random CPU strobes
    // at the block; they must all be ignored.
    task automatic release_and_init();
        int n;
        RESET_N = 1'b1;
        n = 0;
        while (PAL_BUSY === 1'b1 && n < 1000) begin
            PAL_WR       = 1'($urandom_range(0, 1));
            PAL_DATA     = 8'($urandom);
            PAL_ADR_WE   = 1'($urandom_range(0, 1));
            PAL_ADR_DATA = 8'($urandom);
            step();
            n++;
        end
        PAL_WR = 1'b0; PAL_ADR_WE = 1'b0;
        model_reset();
        $display("init busy_cycles=%0d", n);
        chk("init_busy_cycles", 32'(n), 32'd256);
        chk("init_ptr", 32'(PAL_PTR), 32'(m_ptr));
    endtask

    initial begin
        int op;
        model_reset();
        #2;
        chk("rst_ptr", 32'(PAL_PTR), 32'd0);
        chk("rst_busy", 32'(PAL_BUSY), 32'd1);
        chk("rst_vid", 32'({VID_R, VID_G, VID_B}), 32'd0);
        step();
        step();

        release_and_init();
        read_rgb("def3", 3, 3, 7, 3);
        read_rgb("def15", 15, 7, 7, 7);
        read_rgb("def200", 200, 0, 0, 0);
        read_rgb("def0", 0, 0, 0, 0);

        set_ptr(8'd5);
        pulse_wr(8'h72);
        pulse_wr(8'h04);
        chk("ptr_after_5", 32'(PAL_PTR), 32'd6);
        read_rgb("wr5", 5, 7, 4, 2);

        set_ptr(8'd255);
        pulse_wr(8'h11);
        pulse_wr(8'h01);
        chk("ptr_wrap", 32'(PAL_PTR), 32'd0);
        read_rgb("wr255", 255, 1, 1, 1);

        // Pointer load in the same cycle as the second data byte wins.
        pulse_wr(8'h77);
        PAL_WR = 1'b1; PAL_DATA = 8'h07; PAL_ADR_WE = 1'b1; PAL_ADR_DATA = 8'd9;
        step();
        PAL_WR = 1'b0; PAL_ADR_WE = 1'b0;
        m_ptr = 9; m_phase = 0;
        $display("adr+wr ptr<=9 data=0x07 dropped");
        chk("ptr_adr_wins", 32'(PAL_PTR), 32'd9);
        read_rgb("entry0_kept", 0, 0, 0, 0);
        read_rgb("entry9_pre", 9, 7, 3, 3);
        pulse_wr(8'h00);
        pulse_wr(8'h00);
        read_rgb("entry9_new", 9, 0, 0, 0);
        chk("ptr_after_9", 32'(PAL_PTR), 32'd10);

        // Collision: write entry 7 on the same edge that samples VID_ADR=7.
        set_ptr(8'd7);
        pulse_wr(8'h55);
        PAL_WR = 1'b1; PAL_DATA = 8'h03; VID_ADR = 8'd7;
        step();
        PAL_WR = 1'b0;
        model_wr(3);
        $display("rd   collide idx=7 rgb=(%0d,%0d,%0d)", VID_R, VID_G, VID_B);
        chk("collide_old", 32'({VID_R, VID_G, VID_B}), 32'({3'd2, 3'd6, 3'd7}));
        read_rgb("collide_new", 7, 5, 3, 5);

        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 5));
            if (op == 0) set_ptr(8'($urandom));
            else if (op <= 3) pulse_wr(8'($urandom));
            else read_model("rand_rd", int'($urandom_range(0, 255)));
        end
        chk("rand_ptr", 32'(PAL_PTR), 32'(m_ptr));
        read_model("rand_last", m_ptr);

        // Reset mid-pair restarts INIT from entry 0.
        set_ptr(8'd5);
        pulse_wr(8'h66);
        RESET_N = 1'b0;
        #2;
        chk("midrst_ptr", 32'(PAL_PTR), 32'd0);
        chk("midrst_busy", 32'(PAL_BUSY), 32'd1);
        chk("midrst_vid", 32'({VID_R, VID_G, VID_B}), 32'd0);
        step();
        release_and_init();
        read_rgb("reinit5", 5, 2, 3, 7);
        read_rgb("reinit9", 9, 7, 3, 3);
        pulse_wr(8'h12);
        pulse_wr(8'h03);
        read_rgb("post_rst_wr0", 0, 1, 3, 2);
        chk("post_rst_ptr", 32'(PAL_PTR), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vdp_palette_rgb.md
# vdp_palette_rgb

Parametrised RGB palette RAM for the VDP colour path: a CPU-side port that accepts the two-byte palette write sequence with an auto-incrementing index, and a video-side read port returning R, G and B for one palette index per clock. After reset an internal sequencer loads the default MSX palette into the RAM, so no preloaded memory image is needed. It replaces the per-channel single-port palette blocks and sits between the CPU register interface and the colour output stage.

## Interface
Parameters:
- ADDR_BITS, 8, palette index width; 2^ADDR_BITS entries.
- CH_BITS, 3, bits per colour channel; legal values are 3 and 4.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- PAL_ADR_WE  in  1  one-cycle strobe: load the palette pointer from PAL_ADR_DATA.
- PAL_ADR_DATA  in  ADDR_BITS  new palette pointer value.
- PAL_WR  in  1  one-cycle strobe: CPU palette data byte on PAL_DATA.
- PAL_DATA  in  8  CPU palette data byte.
- PAL_PTR  out  ADDR_BITS  current palette pointer.
- PAL_BUSY  out  1  high while the default-palette load runs.
- VID_ADR  in  ADDR_BITS  video read index.
- VID_R, VID_G, VID_B  out  CH_BITS each  colour of the entry at VID_ADR, registered.

## Operation
- Storage: 2^ADDR_BITS entries of 3*CH_BITS bits ({R,G,B}). One write port (sequencer or CPU), one read port (video). Must infer a single block RAM.
- FSM states: INIT, FIRST, SECOND.
- INIT: entered on reset. An internal counter runs from 0 to 2^ADDR_BITS-1 and writes one entry per cycle.
  - Entries 0–15 receive the default palette, given as (R,G,B) per index: 0:(0,0,0), 1:(0,0,0), 2:(1,6,1), 3:(3,7,3), 4:(1,1,7), 5:(2,3,7), 6:(5,1,1), 7:(2,6,7), 8:(7,1,1), 9:(7,3,3), 10:(6,6,1), 11:(6,6,4), 12:(1,4,1), 13:(6,2,5), 14:(5,5,5), 15:(7,7,7).
  - With CH_BITS=4, each default value is shifted left by 1 (LSB = 0).
  - All other entries are written to 0.
  - After the last entry is written, the FSM moves to FIRST and PAL_BUSY falls.
  - PAL_WR and PAL_ADR_WE are ignored in INIT (dropped, not queued).
- FIRST: on PAL_WR, latch R = PAL_DATA[4+CH_BITS-1:4] and B = PAL_DATA[CH_BITS-1:0], then go to SECOND. The RAM is not written.
- SECOND: on PAL_WR, set G = PAL_DATA[CH_BITS-1:0] and write {R,G,B} to entry PAL_PTR. On the same edge, PAL_PTR increments and the FSM returns to FIRST.
- Pointer increment wraps from 2^ADDR_BITS-1 to 0.
- PAL_ADR_WE (FIRST or SECOND): PAL_PTR is set to PAL_ADR_DATA and the FSM goes to FIRST. Any latched R/B is discarded.
- PAL_ADR_WE and PAL_WR in the same cycle: PAL_ADR_WE wins and PAL_WR is dropped.
- Unused PAL_DATA bits are ignored.

## Timing
- Reset values: PAL_PTR=0, PAL_BUSY=1, VID_R/G/B=0, state INIT, latched R/B=0.
- RAM contents are not reset. A reset asserted mid-INIT or mid-sequence restarts INIT from entry 0.
- INIT lasts exactly 2^ADDR_BITS cycles after RESET_N deasserts. PAL_BUSY is low on the cycle after the final write.
- Video read latency is 1 cycle: VID_ADR sampled at edge n gives its colour on VID_R/G/B after edge n.
- Video reads are permitted during INIT. They return the current RAM contents, which may be partially initialised.
- CPU write: the RAM is updated at the edge that samples the second PAL_WR. PAL_PTR shows the incremented value after that edge.
- Read/write collision (same index, same edge): the video port returns the old data. The new data is visible from the next read.
- Back-to-back PAL_WR on consecutive cycles is legal. Full throughput is one entry per two strobes.

## Test plan
- Reset release with ADDR_BITS=8, CH_BITS=3 → PAL_BUSY high for exactly 256 cycles. Then VID_ADR=3 gives (3,7,3), VID_ADR=15 gives (7,7,7), VID_ADR=200 gives (0,0,0).
- PAL_ADR_WE with data 5, then PAL_WR 0x72, then PAL_WR 0x04 → entry 5 reads (7,4,2) and PAL_PTR=6.
- PAL_PTR=255, then write 0x11, 0x01 → entry 255 = (1,1,1) and PAL_PTR wraps to 0.
- PAL_WR 0x77, then PAL_ADR_WE=9 asserted in the same cycle as the second PAL_WR (0x07) → no RAM write, PAL_PTR=9, FSM in FIRST. The next pair 0x00, 0x00 writes entry 9.
- PAL_WR pulses during INIT → ignored. After INIT, entry 0 = (0,0,0) and PAL_PTR=0.
- Second PAL_WR to entry 7 in the same cycle that VID_ADR=7 is sampled → old (2,6,7) is output that cycle. The next read returns the new value. Reset asserted mid-pair restarts INIT and sets PAL_PTR=0.
